// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_seq_pc_reg_en.sv
// PC storage: a load-enabled register that resets asynchronously to RESET_VECTOR.
module pc_reg_en #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // PC register with load enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VECTOR;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC (sequential, branch, jump, trap),
// offers it to fetch over valid/ready and supports halt/resume.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              trap,
  input  logic              halt,
  input  logic              resume,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] target);
    return {target[ADDR_W-1:2], 2'b00};
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic              pc_en_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic              cnt_inc_s;
  logic [CNT_W-1:0]  fetch_cnt_r;

  pc_reg_en #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en_s),
    .d   (pc_next_s),
    .q   (pc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, next PC and accept counting; an accept still counts when a
  // redirect overrides the sequential PC in the same cycle.
  always_comb begin
    state_next_s = state_r;
    pc_en_s      = 1'b0;
    pc_next_s    = pc;
    cnt_inc_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        cnt_inc_s = fetch_ready;
        if (trap) begin
          pc_en_s   = 1'b1;
          pc_next_s = align_target(TRAP_VECTOR);
        end else if (jump) begin
          pc_en_s   = 1'b1;
          pc_next_s = align_target(jump_target);
        end else if (branch_take) begin
          pc_en_s   = 1'b1;
          pc_next_s = align_target(branch_target);
        end else if (fetch_ready) begin
          pc_en_s   = 1'b1;
          pc_next_s = pc + ADDR_W'(INSN_BYTES);
        end else begin
          pc_en_s   = 1'b0;
        end
        if (halt) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (trap) begin
          pc_en_s      = 1'b1;
          pc_next_s    = align_target(TRAP_VECTOR);
          state_next_s = ST_RUN;
        end else if (resume) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: begin
        state_next_s = ST_BOOT;
      end
    endcase
  end

  // Accepted-fetch counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      fetch_cnt_r <= fetch_cnt_r + CNT_W'(1'b1);
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  assign fetch_cnt   = fetch_cnt_r;
  assign fetch_valid = (state_r == ST_RUN);
  assign halted      = (state_r == ST_HALT);

endmodule
